// File: rtl/alu_arbiter_if.sv
// Request/response bundle for the two requesters sharing one ALU.
// The requester side (master) drives operations and response ready.
interface alu_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [3:0]  req0_op;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic        rsp0_valid;
   logic        rsp0_ready;
   logic [31:0] rsp0_result;
   logic        rsp0_zero;
   logic        rsp0_err;

   logic        req1_valid;
   logic        req1_ready;
   logic [3:0]  req1_op;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic        rsp1_valid;
   logic        rsp1_ready;
   logic [31:0] rsp1_result;
   logic        rsp1_zero;
   logic        rsp1_err;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
      output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
      input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
      input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
      input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
      output req0_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
      output req1_ready, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters,
// with registered operands and registered per-port responses.

module alu32bit (
   input  logic [3:0]  alu_control,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] alu_result,
   output logic        zero
);
   always_comb begin
      alu_result = 32'd0;
      case (alu_control)
         4'b0000: alu_result = a & b;
         4'b0001: alu_result = a | b;
         4'b0010: alu_result = a + b;
         4'b0110: alu_result = a - b;
         4'b0111: alu_result = {31'd0, ($signed(a) < $signed(b))};
         4'b1100: alu_result = ~(a | b);
         default: alu_result = 32'd0;
      endcase
   end

   assign zero = (alu_result == 32'd0);
endmodule

// state | meaning
// IDLE  | waiting for a request; winner sees req ready
// EXEC  | latched operands drive the ALU; result captured at cycle end
// RESP  | granted port holds rsp valid until its rsp ready
module alu_arbiter #(
   parameter bit PRIORITY_INIT = 1'b0
) (
   input  logic          Clk,
   input  logic          Reset,
   alu_arbiter_if.slave  bus,
   output logic          busy
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        gnt_q;
   logic        pri_q;
   logic [3:0]  op_q;
   logic [31:0] a_q, b_q;

   logic [31:0] res0_q, res1_q;
   logic        zero0_q, zero1_q;
   logic        err0_q, err1_q;

   logic        win;
   logic        ready0, ready1;
   logic        accept;
   logic        rsp_fire;
   logic        op_legal;

   logic [31:0] alu_result;
   logic        alu_zero;

   alu32bit u_alu (
      .alu_control (op_q),
      .a           (a_q),
      .b           (b_q),
      .alu_result  (alu_result),
      .zero        (alu_zero)
   );

   always_comb begin
      op_legal = 1'b0;
      case (op_q)
         4'b0000, 4'b0001, 4'b0010,
         4'b0110, 4'b0111, 4'b1100: op_legal = 1'b1;
         default:                   op_legal = 1'b0;
      endcase
   end

   // Ties go to the pointer; a lone requester always wins.
   always_comb begin
      win = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         win = pri_q;
      end else if (bus.req1_valid) begin
         win = 1'b1;
      end
   end

   assign ready0   = !Reset && (state_q == ST_IDLE) && bus.req0_valid && !win;
   assign ready1   = !Reset && (state_q == ST_IDLE) && bus.req1_valid && win;
   assign accept   = ready0 || ready1;
   assign rsp_fire = (state_q == ST_RESP) && (gnt_q ? bus.rsp1_ready : bus.rsp0_ready);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)   state_d = ST_EXEC;
         ST_EXEC:               state_d = ST_RESP;
         ST_RESP: if (rsp_fire) state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         gnt_q   <= 1'b0;
         pri_q   <= PRIORITY_INIT;
         op_q    <= 4'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         res0_q  <= 32'd0;
         res1_q  <= 32'd0;
         zero0_q <= 1'b0;
         zero1_q <= 1'b0;
         err0_q  <= 1'b0;
         err1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            gnt_q <= ready1;
            op_q  <= ready1 ? bus.req1_op : bus.req0_op;
            a_q   <= ready1 ? bus.req1_a  : bus.req0_a;
            b_q   <= ready1 ? bus.req1_b  : bus.req0_b;
         end
         // Unsupported codes never expose the ALU output.
         if (state_q == ST_EXEC) begin
            if (gnt_q) begin
               res1_q  <= op_legal ? alu_result : 32'd0;
               zero1_q <= op_legal ? alu_zero   : 1'b1;
               err1_q  <= !op_legal;
            end else begin
               res0_q  <= op_legal ? alu_result : 32'd0;
               zero0_q <= op_legal ? alu_zero   : 1'b1;
               err0_q  <= !op_legal;
            end
         end
         if (rsp_fire) begin
            pri_q <= !gnt_q;
         end
      end
   end

   assign bus.req0_ready  = ready0;
   assign bus.req1_ready  = ready1;
   assign bus.rsp0_valid  = !Reset && (state_q == ST_RESP) && !gnt_q;
   assign bus.rsp1_valid  = !Reset && (state_q == ST_RESP) && gnt_q;
   assign bus.rsp0_result = res0_q;
   assign bus.rsp0_zero   = zero0_q;
   assign bus.rsp0_err    = err0_q;
   assign bus.rsp1_result = res1_q;
   assign bus.rsp1_zero   = zero1_q;
   assign bus.rsp1_err    = err1_q;
   assign busy            = (state_q != ST_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_alu_arbiter;
   logic Clk = 1'b0;
   logic Reset = 1'b1;
   logic busy;

   alu_arbiter_if bus ();

   alu_arbiter #(.PRIORITY_INIT(1'b0)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 Clk = ~Clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit started = 1'b0;

   // Each requester presents an op while it still owes issued operations.
   int want0 = 0, done0 = 0, want1 = 0, done1 = 0;
   assign bus.req0_valid = (want0 != done0);
   assign bus.req1_valid = (want1 != done1);

   bit acc0 = 1'b0, acc1 = 1'b0;

   typedef struct {
      bit          port;
      logic [31:0] res;
      bit          zero;
      bit          err;
      int          cyc;
   } rsp_t;
   rsp_t rlog[$];
   int   glog[$];
   int   gcyc[$];

   // Reference model: one op in flight, age counts edges since accept.
   bit          m_busy = 1'b0;
   bit          m_who = 1'b0;
   int          m_age = 0;
   bit          m_pri = 1'b0;
   logic [31:0] m_res = 32'd0;
   bit          m_zero = 1'b0;
   bit          m_err = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output bit z, output bit e);
      e = 1'b0;
      case (op)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  r = a + b;
         4'd6:  r = a - b;
         4'd7:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd12: r = ~(a | b);
         default: begin r = 32'd0; e = 1'b1; end
      endcase
      z = (r == 32'd0);
   endtask

   always @(negedge Clk) begin
      bit e_rdy0, e_rdy1, e_val0, e_val1;
      cyc++;
      acc0 = 1'b0;
      acc1 = 1'b0;
      if (started) begin
         e_rdy0 = !Reset && !m_busy && bus.req0_valid && !(bus.req1_valid && m_pri);
         e_rdy1 = !Reset && !m_busy && bus.req1_valid && !(bus.req0_valid && !m_pri);
         e_val0 = !Reset && m_busy && m_age >= 1 && !m_who;
         e_val1 = !Reset && m_busy && m_age >= 1 && m_who;
         chk("req0_ready", bus.req0_ready, e_rdy0);
         chk("req1_ready", bus.req1_ready, e_rdy1);
         chk("rsp0_valid", bus.rsp0_valid, e_val0);
         chk("rsp1_valid", bus.rsp1_valid, e_val1);
         chk("busy", busy, m_busy);
         if (e_val0) begin
            chk("rsp0_result", bus.rsp0_result, m_res);
            chk("rsp0_zero", bus.rsp0_zero, m_zero);
            chk("rsp0_err", bus.rsp0_err, m_err);
         end
         if (e_val1) begin
            chk("rsp1_result", bus.rsp1_result, m_res);
            chk("rsp1_zero", bus.rsp1_zero, m_zero);
            chk("rsp1_err", bus.rsp1_err, m_err);
         end

         acc0 = bus.req0_valid && bus.req0_ready;
         acc1 = bus.req1_valid && bus.req1_ready;
         if (acc0) begin glog.push_back(0); gcyc.push_back(cyc); end
         if (acc1) begin glog.push_back(1); gcyc.push_back(cyc); end
         if (bus.rsp0_valid && bus.rsp0_ready)
            rlog.push_back('{1'b0, bus.rsp0_result, bus.rsp0_zero, bus.rsp0_err, cyc});
         if (bus.rsp1_valid && bus.rsp1_ready)
            rlog.push_back('{1'b1, bus.rsp1_result, bus.rsp1_zero, bus.rsp1_err, cyc});

         // Inputs are stable from here to the next rising edge.
         if (Reset) begin
            m_busy = 1'b0;
            m_pri  = 1'b0;
         end else if (!m_busy) begin
            if (e_rdy0 || e_rdy1) begin
               m_busy = 1'b1;
               m_who  = e_rdy1;
               m_age  = 0;
               if (e_rdy1) ref_alu(bus.req1_op, bus.req1_a, bus.req1_b, m_res, m_zero, m_err);
               else        ref_alu(bus.req0_op, bus.req0_a, bus.req0_b, m_res, m_zero, m_err);
            end
         end else if (m_age >= 1 && (m_who ? bus.rsp1_ready : bus.rsp0_ready)) begin
            m_busy = 1'b0;
            m_pri  = !m_who;
         end else begin
            m_age++;
         end
      end
   end

   always @(posedge Clk) begin
      if (acc0 || acc1) begin
         #1;
         if (acc0) done0++;
         if (acc1) done1++;
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
   endtask

   task automatic wait_quiet(input int maxc, input string name);
      int n = 0;
      bit timed_out = 1'b0;
      @(negedge Clk);
      while (!(want0 == done0 && want1 == done1 && !busy)) begin
         n++;
         if (n > maxc) begin
            timed_out = 1'b1;
            break;
         end
         @(negedge Clk);
      end
      chk({"timeout_", name}, timed_out, 1'b0);
      tick();
   endtask

   task automatic chk_rsp(input string name, input int idx, input bit port,
                          input logic [31:0] res, input bit zero, input bit err);
      if (rlog.size() <= idx) begin
         chk({name, "_present"}, rlog.size(), idx + 1);
      end else begin
         chk({name, "_port"}, rlog[idx].port, port);
         chk({name, "_result"}, rlog[idx].res, res);
         chk({name, "_zero"}, rlog[idx].zero, zero);
         chk({name, "_err"}, rlog[idx].err, err);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
      $fatal(1);
   end

   initial begin
      int n, g, k;
      bit seen;
      bus.req0_op = 4'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
      bus.req1_op = 4'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      Reset = 1'b1;
      tick();
      started = 1'b1;
      tick();
      Reset = 1'b0;
      @(negedge Clk);
      chk("reset_busy", busy, 1'b0);
      chk("reset_rsp0_result", bus.rsp0_result, 32'd0);
      chk("reset_rsp1_result", bus.rsp1_result, 32'd0);
      chk("reset_zero_err", {bus.rsp0_zero, bus.rsp0_err, bus.rsp1_zero, bus.rsp1_err}, 4'b0000);
      tick();

      // Single ADD on port 0.
      n = rlog.size(); g = gcyc.size();
      bus.req0_op = 4'b0010; bus.req0_a = 32'd5; bus.req0_b = 32'd10;
      want0++;
      wait_quiet(20, "add");
      chk_rsp("add", n, 1'b0, 32'd15, 1'b0, 1'b0);
      chk("add_count", rlog.size() - n, 1);
      if (rlog.size() > n && gcyc.size() > g)
         chk("add_latency", rlog[n].cyc - gcyc[g], 2);

      // Simultaneous requests after reset: port 0 first.
      do_reset();
      n = rlog.size();
      bus.req0_op = 4'b0110; bus.req0_a = 32'd5; bus.req0_b = 32'd5;
      bus.req1_op = 4'b0001; bus.req1_a = 32'd5; bus.req1_b = 32'd10;
      want0++; want1++;
      wait_quiet(30, "simul");
      chk_rsp("simul_first", n, 1'b0, 32'd0, 1'b1, 1'b0);
      chk_rsp("simul_second", n + 1, 1'b1, 32'd15, 1'b0, 1'b0);

      // Continuous contention: strict alternation at one op per 3 cycles.
      do_reset();
      n = rlog.size(); g = glog.size();
      bus.req0_op = 4'b0111; bus.req0_a = 32'd3;          bus.req0_b = 32'd7;
      bus.req1_op = 4'b1100; bus.req1_a = 32'hFFFF0000;   bus.req1_b = 32'h0F0F0F0F;
      want0 += 4; want1 += 4;
      wait_quiet(60, "contend");
      for (int i = 0; i < 8; i++) begin
         if (glog.size() > g + i) chk("contend_grant", glog[g + i], i % 2);
         else chk("contend_grant_present", glog.size(), g + i + 1);
         if (i % 2 == 0) chk_rsp("contend_p0", n + i, 1'b0, 32'd1, 1'b0, 1'b0);
         else            chk_rsp("contend_p1", n + i, 1'b1, 32'h0000F0F0, 1'b0, 1'b0);
      end
      if (gcyc.size() > g + 1) chk("contend_period", gcyc[g + 1] - gcyc[g], 3);

      // Response backpressure on port 1 with port 0 waiting.
      do_reset();
      n = rlog.size();
      bus.rsp1_ready = 1'b0;
      bus.req1_op = 4'b0010; bus.req1_a = 32'd7;   bus.req1_b = 32'd8;
      bus.req0_op = 4'b0000; bus.req0_a = 32'hFF;  bus.req0_b = 32'h0F;
      want1++;
      k = 0; seen = 1'b0;
      while (k < 10 && !seen) begin
         @(negedge Clk);
         seen = bus.rsp1_valid;
         k++;
      end
      chk("bp_valid_seen", seen, 1'b1);
      tick();
      want0++;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         chk("bp_hold_result", bus.rsp1_result, 32'd15);
         chk("bp_hold_busy", busy, 1'b1);
         chk("bp_req0_ready", bus.req0_ready, 1'b0);
      end
      tick();
      bus.rsp1_ready = 1'b1;
      wait_quiet(30, "backpressure");
      chk_rsp("bp_first", n, 1'b1, 32'd15, 1'b0, 1'b0);
      chk_rsp("bp_second", n + 1, 1'b0, 32'h0F, 1'b0, 1'b0);

      // Unsupported operation code.
      n = rlog.size();
      bus.req1_op = 4'b1111; bus.req1_a = 32'd9; bus.req1_b = 32'd2;
      want1++;
      wait_quiet(20, "illegal");
      chk_rsp("illegal", n, 1'b1, 32'd0, 1'b1, 1'b1);

      // Reset while the op is in EXEC discards it.
      bus.req0_op = 4'b0010; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
      want0++;
      k = 0; seen = 1'b0;
      while (k < 10 && !seen) begin
         @(negedge Clk);
         seen = bus.req0_ready;
         k++;
      end
      chk("midreset_accept_seen", seen, 1'b1);
      tick();
      n = rlog.size();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      @(negedge Clk);
      chk("midreset_busy", busy, 1'b0);
      chk("midreset_valids", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
      chk("midreset_rsp0_result", bus.rsp0_result, 32'd0);
      chk("midreset_rsp1_result", bus.rsp1_result, 32'd0);
      chk("midreset_flags", {bus.rsp0_zero, bus.rsp0_err, bus.rsp1_zero, bus.rsp1_err}, 4'b0000);
      tick();
      chk("midreset_no_rsp", rlog.size() - n, 0);
      bus.req0_op = 4'b0010; bus.req0_a = 32'd1;   bus.req0_b = 32'd1;
      bus.req1_op = 4'b0000; bus.req1_a = 32'hF0;  bus.req1_b = 32'hFF;
      want0++; want1++;
      wait_quiet(30, "after_reset");
      chk_rsp("after_reset_first", n, 1'b0, 32'd2, 1'b0, 1'b0);
      chk_rsp("after_reset_second", n + 1, 1'b1, 32'hF0, 1'b0, 1'b0);

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
